// File: rtl/logic_op_pipe.sv
// Pipelined AND/OR/XOR/pass-A unit with operand/result complement, zero flag and delivered-result counter.
// Latency STAGES edges (result computed in stage 1); global stall on out_valid && !out_ready holds every stage.
module logic_op_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             neg_b,
    input  logic             neg_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [15:0]      res_count
);

    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_r;
    logic [WIDTH-1:0]  w_y;
    logic              w_zero;
    logic              w_stall;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_zero;
    logic [WIDTH-1:0]  r_y [STAGES];
    logic [15:0]       r_count;

    assign w_b = neg_b ? ~b : b;

    always_comb begin
        w_r = a;
        case (op)
            2'b00:   w_r = a & w_b;
            2'b01:   w_r = a | w_b;
            2'b10:   w_r = a ^ w_b;
            default: w_r = a;
        endcase
    end

    assign w_y    = neg_res ? ~w_r : w_r;
    assign w_zero = (w_y == '0);

    assign out_valid = r_vld[STAGES-1];
    assign y         = r_y[STAGES-1];
    assign zero      = r_zero[STAGES-1];
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !out_valid || out_ready;
    assign res_count = r_count;

    // Bubbles shift through like real entries; data of an invalid stage is don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_zero <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_y[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0]  <= in_valid;
            r_y[0]    <= w_y;
            r_zero[0] <= w_zero;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_y[i]    <= r_y[i-1];
                r_zero[i] <= r_zero[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (out_valid && out_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized and directed bench for logic_op_pipe against a queue-based reference model.
module tb_logic_op_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0, y;
    logic [1:0]  op = '0;
    logic        neg_b = 1'b0, neg_res = 1'b0;
    logic        out_valid, out_ready = 1'b0, zero;
    logic [15:0] res_count;

    logic        d8_in_valid = 1'b0, d8_in_ready;
    logic [7:0]  d8_a = '0, d8_b = '0, d8_y;
    logic [1:0]  d8_op = '0;
    logic        d8_out_valid, d8_out_ready = 1'b0, d8_zero;
    logic [15:0] d8_res_count;

    int errs = 0;
    int checks = 0;

    logic        c_acc, c_xfer, c_ovld, c_irdy, c_zero;
    logic [31:0] c_y;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    logic_op_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .neg_b(neg_b), .neg_res(neg_res),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .res_count(res_count)
    );

    logic_op_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .op(d8_op), .neg_b(1'b0), .neg_res(1'b0),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .y(d8_y), .zero(d8_zero),
        .res_count(d8_res_count)
    );

    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [1:0] mop, input logic nb, input logic nr);
        logic [31:0] bb;
        logic [31:0] r;
        bb = nb ? ~mb : mb;
        case (mop)
            2'd0:    r = ma & bb;
            2'd1:    r = ma | bb;
            2'd2:    r = ma ^ bb;
            default: r = ma;
        endcase
        return nr ? ~r : r;
    endfunction

    // One clock: drive at negedge, capture pre-edge view, feed the model on acceptance.
    task automatic drive(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [1:0] iop, input logic nb, input logic nr, input logic ordy);
        @(negedge clk);
        in_valid = v; a = ia; b = ib; op = iop; neg_b = nb; neg_res = nr; out_ready = ordy;
        #1;
        c_ovld = out_valid; c_irdy = in_ready; c_y = y; c_zero = zero;
        c_acc  = v && in_ready;
        c_xfer = out_valid && ordy;
        if (c_acc) q.push_back(model(ia, ib, iop, nb, nr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d8_in_valid = 1'b0; d8_out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (y !== 32'h0) begin errs++; $display("FAIL reset_y got %h want 0", y); end
        checks++; if (zero !== 1'b0) begin errs++; $display("FAIL reset_zero got %b want 0", zero); end
        checks++; if (res_count !== 16'h0) begin errs++; $display("FAIL reset_count got %0d want 0", res_count); end
        checks++; if (d8_out_valid !== 1'b0) begin errs++; $display("FAIL reset_d8_out_valid got %b want 0", d8_out_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_xor_stream();
        logic [31:0] bs [3];
        logic [31:0] ex [3];
        bs[0] = 32'h00000000; bs[1] = 32'h00FFFFFF; bs[2] = 32'h00FFF000;
        ex[0] = 32'h00F010FF; ex[1] = 32'h000FEF00; ex[2] = 32'h000FE0FF;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, 32'h00F010FF, (i < 3) ? bs[i] : 32'h0, 2'd2, 1'b0, 1'b0, 1'b1);
            checks++;
            if (c_ovld !== (i >= 2 && i <= 4)) begin
                errs++; $display("FAIL xor_valid cycle %0d got %b want %b", i, c_ovld, (i >= 2 && i <= 4));
            end
            if (i >= 2 && i <= 4) begin
                checks++; if (c_y !== ex[i-2]) begin errs++; $display("FAIL xor_y cycle %0d got %h want %h", i, c_y, ex[i-2]); end
                checks++; if (c_zero !== 1'b0) begin errs++; $display("FAIL xor_zero cycle %0d got %b want 0", i, c_zero); end
            end
        end
        checks++; if (res_count !== 16'd3) begin errs++; $display("FAIL xor_count got %0d want 3", res_count); end
    endtask

    task automatic test_options();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [1:0]  to [4];
        logic        tn [4];
        logic        tr [4];
        logic [31:0] ey [4];
        logic        ez [4];
        int k;
        ta[0] = 32'hFFFF0000; tb[0] = 32'h0F0F0F0F; to[0] = 2'd0; tn[0] = 1; tr[0] = 0; ey[0] = 32'hF0F00000; ez[0] = 0;
        ta[1] = 32'h0;        tb[1] = 32'h0;        to[1] = 2'd1; tn[1] = 0; tr[1] = 1; ey[1] = 32'hFFFFFFFF; ez[1] = 0;
        ta[2] = 32'h12345678; tb[2] = 32'h12345678; to[2] = 2'd2; tn[2] = 0; tr[2] = 0; ey[2] = 32'h0;        ez[2] = 1;
        ta[3] = 32'hDEADBEEF; tb[3] = $urandom;     to[3] = 2'd3; tn[3] = 1; tr[3] = 0; ey[3] = 32'hDEADBEEF; ez[3] = 0;
        do_reset();
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, ta[i], tb[i], to[i], tn[i], tr[i], 1'b1);
            else       drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
            if (c_xfer && k < 4) begin
                checks++; if (c_y !== ey[k]) begin errs++; $display("FAIL opt_y idx %0d got %h want %h", k, c_y, ey[k]); end
                checks++; if (c_zero !== ez[k]) begin errs++; $display("FAIL opt_zero idx %0d got %b want %b", k, c_zero, ez[k]); end
                k++;
            end
        end
        checks++; if (k !== 4) begin errs++; $display("FAIL opt_delivered got %0d want 4", k); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ra [4];
        logic [31:0] rb [4];
        logic [31:0] held;
        logic [31:0] e;
        int s, d;
        for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
        do_reset();
        s = 0; d = 0; held = '0;
        for (int i = 0; i < 14; i++) begin
            drive(s < 4, (s < 4) ? ra[s] : 32'h0, (s < 4) ? rb[s] : 32'h0, 2'd2, 1'b0, 1'b0, !(i >= 2 && i < 5));
            if (c_acc) s++;
            if (i == 2) held = c_y;
            if (i >= 2 && i < 5) begin
                checks++; if (c_ovld !== 1'b1) begin errs++; $display("FAIL bp_valid_held cycle %0d got %b want 1", i, c_ovld); end
                checks++; if (c_irdy !== 1'b0) begin errs++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, c_irdy); end
                checks++; if (c_y !== held) begin errs++; $display("FAIL bp_y_held cycle %0d got %h want %h", i, c_y, held); end
            end
            if (c_xfer) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hX;
                checks++; if (c_y !== e) begin errs++; $display("FAIL bp_order idx %0d got %h want %h", d, c_y, e); end
                d++;
            end
        end
        checks++; if (d !== 4) begin errs++; $display("FAIL bp_delivered got %0d want 4", d); end
        checks++; if (res_count !== 16'd4) begin errs++; $display("FAIL bp_count got %0d want 4", res_count); end
    endtask

    task automatic test_bubbles();
        logic [31:0] e;
        logic        want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i == 0 || i == 2, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
            if (i >= 2 && i <= 5) begin
                want = (i == 2 || i == 4);
                checks++; if (c_ovld !== want) begin errs++; $display("FAIL bubble_valid cycle %0d got %b want %b", i, c_ovld, want); end
            end
            if (c_xfer) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hX;
                checks++; if (c_y !== e) begin errs++; $display("FAIL bubble_y cycle %0d got %h want %h", i, c_y, e); end
            end
        end
        checks++; if (res_count !== 16'd2) begin errs++; $display("FAIL bubble_count got %0d want 2", res_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 32'h11111111, 32'h22222222, 2'd1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h33333333, 32'h44444444, 2'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        checks++; if (y !== 32'h0) begin errs++; $display("FAIL rmid_y got %h want 0", y); end
        checks++; if (zero !== 1'b0) begin errs++; $display("FAIL rmid_zero got %b want 0", zero); end
        checks++; if (res_count !== 16'h0) begin errs++; $display("FAIL rmid_count got %0d want 0", res_count); end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
            checks++; if (c_ovld !== 1'b0) begin errs++; $display("FAIL rmid_ghost cycle %0d got %b want 0", i, c_ovld); end
        end
        checks++; if (res_count !== 16'h0) begin errs++; $display("FAIL rmid_count_after got %0d want 0", res_count); end
    endtask

    task automatic test_random();
        logic        v, ordy, p_stall;
        logic [31:0] p_y, e;
        int d;
        do_reset();
        d = 0; p_stall = 1'b0; p_y = '0;
        for (int i = 0; i < 410; i++) begin
            v    = (i < 400) && ($urandom_range(0, 3) != 0);
            ordy = (i >= 400) || ($urandom_range(0, 2) != 0);
            drive(v, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ordy);
            checks++; if (c_irdy !== (!c_ovld || ordy)) begin errs++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", i, c_irdy, (!c_ovld || ordy)); end
            if (p_stall) begin
                checks++; if (c_ovld !== 1'b1 || c_y !== p_y) begin errs++; $display("FAIL rnd_hold cycle %0d got %b/%h want 1/%h", i, c_ovld, c_y, p_y); end
            end
            if (c_xfer) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hX;
                checks++; if (c_y !== e) begin errs++; $display("FAIL rnd_y idx %0d got %h want %h", d, c_y, e); end
                checks++; if (c_zero !== (e == 32'h0)) begin errs++; $display("FAIL rnd_zero idx %0d got %b want %b", d, c_zero, (e == 32'h0)); end
                d++;
            end
            p_stall = c_ovld && !ordy;
            p_y     = c_y;
        end
        checks++; if (q.size() !== 0) begin errs++; $display("FAIL rnd_lost got %0d pending want 0", q.size()); end
        checks++; if (res_count !== 16'(d)) begin errs++; $display("FAIL rnd_count got %0d want %0d", res_count, d); end
    endtask

    task automatic test_wrap();
        int cnt;
        do_reset();
        @(negedge clk);
        d8_in_valid = 1'b1; d8_a = 8'hA5; d8_b = 8'hFF; d8_op = 2'd2; d8_out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (d8_out_valid !== 1'b1) begin errs++; $display("FAIL w8_valid got %b want 1", d8_out_valid); end
        checks++; if (d8_y !== 8'h5A) begin errs++; $display("FAIL w8_y got %h want 5a", d8_y); end
        checks++; if (d8_zero !== 1'b0) begin errs++; $display("FAIL w8_zero got %b want 0", d8_zero); end
        cnt = 0;
        for (int c = 0; c < 70000 && cnt < 65537; c++) begin
            @(negedge clk);
            d8_out_ready = 1'b1;
            #1;
            if (d8_out_valid && d8_out_ready) cnt++;
        end
        checks++; if (cnt !== 65537) begin errs++; $display("FAIL w8_timeout got %0d transfers want 65537", cnt); end
        @(posedge clk);
        #1;
        d8_in_valid = 1'b0; d8_out_ready = 1'b0;
        checks++; if (d8_res_count !== 16'd1) begin errs++; $display("FAIL w8_count got %0d want 1", d8_res_count); end
        checks++; if (d8_y !== 8'h5A) begin errs++; $display("FAIL w8_y_stream got %h want 5a", d8_y); end
    endtask

    initial begin
        test_reset();
        test_xor_stream();
        test_options();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised, pipelined logical-operation unit for the VCPU-32 execute path. Generalises the combinational 32-bit XOR into a selectable AND/OR/XOR unit with complement options, configurable width and pipeline depth, a zero flag, and a valid/ready handshake with back-pressure. It sits between operand select and the result bus and supplies a delivered-result counter for diagnostics.

## Interface
- WIDTH, 32, operand and result width in bits (8..64).
- STAGES, 2, pipeline depth in register stages (1..4).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set on a/b/op/neg_b/neg_res is valid.
- in_ready  out  1  unit accepts an operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 pass A.
- neg_b  in  1  complement B before the operation (ignored for pass A).
- neg_res  in  1  complement result after the operation.
- out_valid  out  1  y/zero hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  WIDTH  result.
- zero  out  1  y is all zeros (qualified by out_valid).
- res_count  out  16  number of results delivered since reset.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Result: r = op(a, neg_b ? ~b : b); y = neg_res ? ~r : r; zero = (y == 0). Pure bitwise; no carries, no width extension.
- Computation is done in stage 1; later stages only carry y, zero and a valid bit.
- Global stall: stall = out_valid && !out_ready. When stalled, no stage register changes and in_ready = 0. Otherwise all stages shift by one each cycle.
- in_ready = !out_valid || out_ready (combinational from out_ready and state); no path from in_valid to in_ready.
- Input with in_valid = 0 on a non-stalled cycle inserts a bubble (stage valid = 0); bubbles are not compressed.
- Inputs are sampled only on an accepting edge; a/b/op may change freely otherwise.
- res_count increments by 1 on each transfer out; wraps 0xFFFF -> 0x0000.
- Reset (any time, including mid-stream or mid-stall): all stage valid bits 0, y = 0, zero = 0, res_count = 0; in-flight operations are discarded, not delivered. out_valid = 0 and in_ready = 1 immediately on rst assertion.

## Timing
- Latency: operand accepted at edge k appears with out_valid = 1 after edge k + STAGES - 1 (STAGES = 1: visible right after the accepting edge).
- Throughput: one result per cycle with out_ready held high.
- Under back-pressure out_valid, y, zero stay stable until the transfer-out edge.
- Transfer out and transfer in may occur on the same edge; the pipeline shifts normally.
- First edge after rst deassertion may accept an operand.

## Test plan
- XOR, STAGES=2, out_ready=1: a=0x00F010FF with b=0x00000000, 0x00FFFFFF, 0x00FFF000 on consecutive cycles -> y = 0x00F010FF, 0x000FEF00, 0x000FE0FF on three consecutive cycles starting one cycle after the first accept; zero=0; res_count=3.
- Options: AND neg_b a=0xFFFF0000 b=0x0F0F0F0F -> y=0xF0F00000; OR neg_res a=b=0 -> y=0xFFFFFFFF zero=0; XOR a=b=0x12345678 -> y=0 zero=1; pass A a=0xDEADBEEF -> y=0xDEADBEEF.
- Back-pressure: stream 4 XORs, drop out_ready for 3 cycles after first out_valid -> in_ready=0 during stall, y held, all 4 results delivered in order with no loss or duplication, res_count=4.
- Bubbles: in_valid toggling 1,0,1 -> out_valid pattern 1,0,1 with same spacing; res_count=2.
- Reset mid-operation: assert rst asynchronously between edges with 2 results in flight -> out_valid=0, y=0, res_count=0 immediately; nothing delivered after release.
- Counter wrap and width: WIDTH=8, STAGES=1, 65537 transfers -> res_count=1; a=0xA5 b=0xFF XOR -> y=0x5A after one edge.
